kernel_gen_ctrl: RTL and testbench

Sequencer for the Gaussian kernel generator: accepts (sigma, kernel_size) configuration requests over a valid/ready handshake, validates them, pulses the generator's start, and waits for its done with a timeout. It latches the generated kernel sum and publishes kernel_valid. It also grants frame starts to the downstream convolution engine only while a valid kernel is held, so the kernel is never regenerated under a running frame.

---
 rtl/kernel_gen_ctrl.sv | 155 +++++++++++++++
 tb/tb_kernel_gen_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_gen_ctrl.sv
// Sequencer for the Gaussian kernel generator: validates configs, runs the generator, gates frame starts.
// Optional macro KERNEL_CACHE_EN: a repeated config while READY reuses the held kernel.
module kernel_gen_ctrl #(
  parameter int MAX_KERNEL     = 7,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int KW            = $clog2(MAX_KERNEL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [2:0]    cfg_sigma,
  input  logic [KW-1:0] cfg_kernel_size,
  output logic          gen_start,
  output logic [2:0]    gen_sigma,
  output logic [KW-1:0] gen_kernel_size,
  input  logic          gen_done,
  input  logic [31:0]   gen_sum,
  input  logic          frame_req,
  input  logic          frame_busy,
  output logic          frame_grant,
  output logic          kernel_valid,
  output logic [31:0]   kernel_sum,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_READY, S_ERROR} state_e;

  state_e        state_q;
  logic          gen_start_q;
  logic [2:0]    gen_sigma_q;
  logic [KW-1:0] gen_ks_q;
  logic          frame_grant_q;
  logic          grant_hold_q;
  logic          kernel_valid_q;
  logic [31:0]   kernel_sum_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [CW-1:0] cnt_q;

  logic can_cfg;
  logic cfg_fire;
  logic size_bad;
  logic sigma_bad;
  logic cfg_same;

  // Frame requests in READY take precedence over new configurations.
  always_comb begin
    can_cfg = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: can_cfg = 1'b1;
      S_READY:         can_cfg = ~frame_req;
      default:         can_cfg = 1'b0;
    endcase
  end

  assign cfg_ready = ~rst & can_cfg & ~frame_busy;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign size_bad  = ~cfg_kernel_size[0] | (cfg_kernel_size < KW'(3))
                   | ({1'b0, cfg_kernel_size} > (KW+1)'(MAX_KERNEL));
  assign sigma_bad = (cfg_sigma == 3'd0);

`ifdef KERNEL_CACHE_EN
  assign cfg_same = (state_q == S_READY) & (cfg_sigma == gen_sigma_q)
                  & (cfg_kernel_size == gen_ks_q);
`else
  assign cfg_same = 1'b0;
`endif

  // Controller state machine with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      gen_start_q    <= 1'b0;
      gen_sigma_q    <= 3'd0;
      gen_ks_q       <= '0;
      frame_grant_q  <= 1'b0;
      grant_hold_q   <= 1'b0;
      kernel_valid_q <= 1'b0;
      kernel_sum_q   <= 32'd0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
      cnt_q          <= '0;
    end else begin
      gen_start_q   <= 1'b0;
      frame_grant_q <= 1'b0;
      // A held request is re-armed once busy is observed or the request drops.
      if (frame_busy || !frame_req) begin
        grant_hold_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_READY, S_ERROR: begin
          if (cfg_fire) begin
            if (size_bad) begin
              state_q        <= S_ERROR;
              err_q          <= 1'b1;
              err_code_q     <= 2'd1;
              kernel_valid_q <= 1'b0;
            end else if (sigma_bad) begin
              state_q        <= S_ERROR;
              err_q          <= 1'b1;
              err_code_q     <= 2'd2;
              kernel_valid_q <= 1'b0;
            end else if (!cfg_same) begin
              state_q        <= S_START;
              gen_start_q    <= 1'b1;
              gen_sigma_q    <= cfg_sigma;
              gen_ks_q       <= cfg_kernel_size;
              kernel_valid_q <= 1'b0;
              err_q          <= 1'b0;
              err_code_q     <= 2'd0;
            end
          end else if (state_q == S_READY && frame_req && !frame_busy && !grant_hold_q) begin
            frame_grant_q <= 1'b1;
            grant_hold_q  <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (gen_done) begin
            state_q        <= S_READY;
            kernel_sum_q   <= gen_sum;
            kernel_valid_q <= 1'b1;
            cnt_q          <= '0;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= S_ERROR;
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gen_start       = gen_start_q;
  assign gen_sigma       = gen_sigma_q;
  assign gen_kernel_size = gen_ks_q;
  assign frame_grant     = frame_grant_q;
  assign kernel_valid    = kernel_valid_q;
  assign kernel_sum      = kernel_sum_q;
  assign err             = err_q;
  assign err_code        = err_code_q;

endmodule

// File: tb/tb_kernel_gen_ctrl.sv
// Directed self-checking bench for kernel_gen_ctrl (defaults MAX_KERNEL=7, TIMEOUT_CYCLES=256).
module tb_kernel_gen_ctrl;

  localparam int KW = 3;
  localparam int TO = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_sigma;
  logic [KW-1:0] cfg_kernel_size;
  logic          gen_start;
  logic [2:0]    gen_sigma;
  logic [KW-1:0] gen_kernel_size;
  logic          gen_done;
  logic [31:0]   gen_sum;
  logic          frame_req;
  logic          frame_busy;
  logic          frame_grant;
  logic          kernel_valid;
  logic [31:0]   kernel_sum;
  logic          err;
  logic [1:0]    err_code;

  int total = 0;
  int bad   = 0;
  int pulses;

  kernel_gen_ctrl #(.MAX_KERNEL(7), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sigma(cfg_sigma), .cfg_kernel_size(cfg_kernel_size),
    .gen_start(gen_start), .gen_sigma(gen_sigma), .gen_kernel_size(gen_kernel_size),
    .gen_done(gen_done), .gen_sum(gen_sum),
    .frame_req(frame_req), .frame_busy(frame_busy), .frame_grant(frame_grant),
    .kernel_valid(kernel_valid), .kernel_sum(kernel_sum),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] s, input logic [KW-1:0] k);
    cfg_valid = 1'b1;
    cfg_sigma = s;
    cfg_kernel_size = k;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(gen_start), 32'd0);
    chk({tag, "_sigma"}, 32'(gen_sigma), 32'd0);
    chk({tag, "_ks"}, 32'(gen_kernel_size), 32'd0);
    chk({tag, "_grant"}, 32'(frame_grant), 32'd0);
    chk({tag, "_kv"}, 32'(kernel_valid), 32'd0);
    chk({tag, "_sum"}, kernel_sum, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_code"}, 32'(err_code), 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_sigma = 3'd0; cfg_kernel_size = 3'd0;
    gen_done = 1'b0; gen_sum = 32'd0; frame_req = 1'b0; frame_busy = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    frame_req = 1'b1;
    tick(); tick();
    chk("idle_no_grant", 32'(frame_grant), 32'd0);
    frame_req = 1'b0;

    // Basic generation: sigma=2 size=5, done with sum 1234.
    send(3'd2, 3'd5);
    tick();
    cfg_valid = 1'b0;
    chk("t1_start", 32'(gen_start), 32'd1);
    chk("t1_sigma", 32'(gen_sigma), 32'd2);
    chk("t1_ks", 32'(gen_kernel_size), 32'd5);
    pulses = 0;
    for (int i = 0; i < 23; i++) begin
      tick();
      if (gen_start) pulses++;
    end
    chk("t1_single_pulse", 32'(pulses), 32'd0);
    chk("t1_kv_wait", 32'(kernel_valid), 32'd0);
    gen_done = 1'b1; gen_sum = 32'd1234;
    tick();
    gen_done = 1'b0;
    chk("t1_kv", 32'(kernel_valid), 32'd1);
    chk("t1_sum", kernel_sum, 32'd1234);
    chk("t1_cfg_ready", 32'(cfg_ready), 32'd1);

    // Validation errors: size 4, size 9 (truncates to 1), size-before-sigma ordering, sigma 0.
    send(3'd2, 3'd4);
    tick();
    chk("e1_err", 32'(err), 32'd1);
    chk("e1_code", 32'(err_code), 32'd1);
    chk("e1_kv", 32'(kernel_valid), 32'd0);
    chk("e1_start", 32'(gen_start), 32'd0);
    chk("e1_sum_hold", kernel_sum, 32'd1234);
    send(3'd2, KW'(9));
    tick();
    chk("e2_code", 32'(err_code), 32'd1);
    send(3'd0, 3'd4);
    tick();
    chk("e3_order_code", 32'(err_code), 32'd1);
    send(3'd0, 3'd3);
    tick();
    cfg_valid = 1'b0;
    chk("e4_code", 32'(err_code), 32'd2);
    chk("e4_start", 32'(gen_start), 32'd0);
    chk("e4_kv", 32'(kernel_valid), 32'd0);
    frame_req = 1'b1;
    #1;
    chk("err_cfg_ready_with_req", 32'(cfg_ready), 32'd1);
    tick(); tick();
    chk("err_no_grant", 32'(frame_grant), 32'd0);
    frame_req = 1'b0;

    // Timeout: ERROR exactly TO cycles after entering WAIT; late done ignored.
    send(3'd1, 3'd3);
    tick();
    cfg_valid = 1'b0;
    chk("to_start", 32'(gen_start), 32'd1);
    chk("to_err_cleared", 32'(err), 32'd0);
    chk("to_code_cleared", 32'(err_code), 32'd0);
    tick();
    repeat (TO - 1) tick();
    chk("to_not_yet", 32'(err), 32'd0);
    tick();
    chk("to_err", 32'(err), 32'd1);
    chk("to_code", 32'(err_code), 32'd3);
    gen_done = 1'b1; gen_sum = 32'd999;
    tick();
    gen_done = 1'b0;
    chk("to_late_done_kv", 32'(kernel_valid), 32'd0);
    chk("to_late_done_sum", kernel_sum, 32'd1234);
    chk("to_late_done_err", 32'(err), 32'd1);

    // gen_done on the final WAIT cycle beats the timeout.
    send(3'd3, 3'd7);
    tick();
    cfg_valid = 1'b0;
    tick();
    repeat (TO - 1) tick();
    gen_done = 1'b1; gen_sum = 32'd4321;
    tick();
    gen_done = 1'b0;
    chk("prio_kv", 32'(kernel_valid), 32'd1);
    chk("prio_err", 32'(err), 32'd0);
    chk("prio_sum", kernel_sum, 32'd4321);

    // Frame vs config in READY, busy hold-off and re-grant after busy.
    send(3'd1, 3'd3);
    frame_req = 1'b1;
    #1;
    chk("fr_cfg_ready_req", 32'(cfg_ready), 32'd0);
    tick();
    chk("fr_grant1", 32'(frame_grant), 32'd1);
    chk("fr_no_start", 32'(gen_start), 32'd0);
    tick();
    chk("fr_grant_pulse", 32'(frame_grant), 32'd0);
    frame_busy = 1'b1;
    #1;
    chk("fr_cfg_ready_busy", 32'(cfg_ready), 32'd0);
    tick(); tick();
    chk("fr_busy_no_grant", 32'(frame_grant), 32'd0);
    chk("fr_busy_no_start", 32'(gen_start), 32'd0);
    chk("fr_busy_kv", 32'(kernel_valid), 32'd1);
    frame_busy = 1'b0;
    tick();
    chk("fr_regrant", 32'(frame_grant), 32'd1);
    frame_req = 1'b0;
    #1;
    chk("fr_cfg_ready_free", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk("regen_start", 32'(gen_start), 32'd1);
    chk("regen_kv_drop", 32'(kernel_valid), 32'd0);
    chk("regen_sigma", 32'(gen_sigma), 32'd1);
    chk("regen_grant", 32'(frame_grant), 32'd0);
    tick();
    gen_done = 1'b1; gen_sum = 32'd55;
    tick();
    gen_done = 1'b0;
    chk("regen_sum", kernel_sum, 32'd55);

    // Identical configuration while READY.
    send(3'd1, 3'd3);
    tick();
    cfg_valid = 1'b0;
`ifdef KERNEL_CACHE_EN
    chk("same_start", 32'(gen_start), 32'd0);
    chk("same_kv", 32'(kernel_valid), 32'd1);
`else
    chk("same_start", 32'(gen_start), 32'd1);
    chk("same_kv", 32'(kernel_valid), 32'd0);
    tick();
    gen_done = 1'b1; gen_sum = 32'd55;
    tick();
    gen_done = 1'b0;
`endif
    chk("same_after_kv", 32'(kernel_valid), 32'd1);
    gen_done = 1'b1; gen_sum = 32'd77;
    tick();
    gen_done = 1'b0;
    chk("done_outside_wait", kernel_sum, 32'd55);

    // Asynchronous reset during WAIT abandons the run.
    send(3'd4, 3'd7);
    tick();
    cfg_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk_all_zero("rst_wait");
    tick();
    rst = 1'b0;
    gen_done = 1'b1; gen_sum = 32'd88;
    tick();
    gen_done = 1'b0;
    chk("post_rst_kv", 32'(kernel_valid), 32'd0);
    chk("post_rst_sum", kernel_sum, 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_idle_ready", 32'(cfg_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
